wb_cmd_master: RTL and testbench
================================

# wb_cmd_master

Wishbone classic single-transfer initiator that turns a valid/ready command stream into one bus cycle at a time and returns the result on a valid/ready response stream. It drives the user-project Wishbone slave port from the initiator side. Uses: on-chip test sequencers, LA-driven bring-up, and bench stimulus. It adds a bus-error path and a programmable no-acknowledge timeout so a hung slave cannot stall the command source.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles STB stays high without ACK/ERR. Legal range 2..255; the counter is 8 bits.
- wb_clk_i  in  1  single clock; all logic on rising edge
- wb_rst_ni  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  block can accept a command
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_adr_i  in  32  byte address
- cmd_dat_i  in  32  write data
- cmd_sel_i  in  4  byte selects
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumer ready
- rsp_dat_o  out  32  read data; 0 for writes, errors and timeouts
- rsp_err_o  out  1  transfer ended by ERR or timeout
- rsp_tmo_o  out  1  transfer ended by timeout (implies rsp_err_o)
- wbm_cyc_o, wbm_stb_o  out  1  bus cycle / strobe; always equal
- wbm_we_o  out  1  write enable
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_sel_o  out  4  byte selects
- wbm_ack_i  in  1  slave acknowledge
- wbm_err_i  in  1  slave error
- wbm_dat_i  in  32  slave read data
- busy_o  out  1  state is not IDLE

## Operation
- FSM states:
  - IDLE: cmd_ready_o = 1. On cmd_valid_i & cmd_ready_o, register we/adr/dat/sel onto the wbm_* outputs, clear the timeout counter and go to BUS.
  - BUS: cyc/stb = 1 and all wbm_* outputs held stable.
    - ACK and ERR both low: the counter increments.
    - ACK high, ERR low: capture wbm_dat_i if it is a read (0 for a write), set err = 0, tmo = 0, go to RESP.
    - ERR high (ACK high or low): data = 0, err = 1, tmo = 0, go to RESP. ERR has priority over ACK.
    - No ACK/ERR at the edge where counter = TIMEOUT_CYCLES-1: data = 0, err = 1, tmo = 1, go to RESP.
  - RESP: rsp_valid_o = 1 and the response fields are held stable. On rsp_ready_i go to IDLE.
- All outputs are registered. cmd_ready_o, rsp_valid_o and busy_o decode directly from the state register.
- cyc/stb drop on the same edge that leaves BUS.
- wbm_ack_i and wbm_err_i are ignored outside BUS. This covers a registered-ack slave that presents a trailing ACK one cycle after STB drops. That ACK must not be counted as a response.
- Outstanding transfers: at most one. There is no pipelining or burst support.
- rsp_dat_o holds its value until the next capture. wbm_adr_o, wbm_dat_o, wbm_sel_o and wbm_we_o hold the last command after the transfer.
- Reset values: state IDLE, cyc/stb 0, we 0, adr/dat/sel 0, rsp_valid 0, rsp_dat 0, rsp_err 0, rsp_tmo 0, counter 0. From reset, cmd_ready_o = 1 and busy_o = 0.
- Reset asserted mid-transfer forces cyc/stb low immediately (asynchronous). The pending command and any unconsumed response are discarded.

## Timing
- A command accepted at edge N puts cyc/stb high from just after N.
- A slave ACKing combinationally in the first STB cycle is sampled at N+1. rsp_valid_o is then high after N+1.
- Registered-ACK slave (ACK = registered stb & cyc): ACK is sampled at N+2 and rsp_valid_o rises after N+2. Its trailing ACK in the following cycle is ignored.
- Minimum command-to-command spacing is 3 cycles: IDLE, BUS, RESP with rsp_ready_i held high.
- Timeout: STB is high for exactly TIMEOUT_CYCLES cycles. rsp_valid_o rises after edge N+TIMEOUT_CYCLES.
- ACK on the same edge as the timeout limit counts as a normal ACK.
- rsp_valid_o and the response fields stay stable while rsp_ready_i is low. cmd_ready_o stays 0 throughout BUS and RESP.

## Test plan
- Write 0xA5A5_0001 to 0x3000_0004 with sel 0xF against a registered-ACK slave:
  - cyc/stb high for exactly 2 cycles;
  - rsp_valid_o after N+2 with err 0 and dat 0;
  - the trailing ACK is ignored: no second response, state stays IDLE.
- Read from 0x3000_0000 with the slave returning 0x1234_5678 and a combinational ACK in cycle 1: rsp_dat_o = 0x1234_5678, rsp_err_o = 0, rsp_valid_o after N+1.
- Slave asserts ACK and ERR together on a read: rsp_err_o = 1, rsp_tmo_o = 0, rsp_dat_o = 0.
- TIMEOUT_CYCLES = 4 with a silent slave:
  - STB high for exactly 4 cycles;
  - rsp_err_o = 1, rsp_tmo_o = 1, dat 0;
  - the next command is accepted normally.
- Hold rsp_ready_i low for 3 cycles after a read: rsp_valid_o and rsp_dat_o are stable, cmd_ready_o = 0, and a cmd_valid_i presented meanwhile is not accepted until after the response handshake.
- Assert wb_rst_ni low in the second BUS cycle: cyc/stb drop before the next edge, rsp_valid_o = 0, and cmd_ready_o = 1 after release.

Source files
------------

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: valid/ready command in, one bus cycle, valid/ready response out.
// Latency: cyc/stb the cycle after accept, response the cycle after ACK/ERR/timeout; command stalls while busy or response unconsumed.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        rsp_tmo_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_tmo_q, rsp_tmo_d;

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        rsp_tmo_d = rsp_tmo_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    we_d    = cmd_we_i;
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    sel_d   = cmd_sel_i;
                    cnt_d   = 8'd0;
                    state_d = BUS;
                end
            end
            BUS: begin
                // ERR wins over ACK; ACK on the limit edge is still a normal completion
                if (wbm_err_i) begin
                    rsp_dat_d = 32'd0;
                    rsp_err_d = 1'b1;
                    rsp_tmo_d = 1'b0;
                    state_d   = RESP;
                end else if (wbm_ack_i) begin
                    rsp_dat_d = we_q ? 32'd0 : wbm_dat_i;
                    rsp_err_d = 1'b0;
                    rsp_tmo_d = 1'b0;
                    state_d   = RESP;
                end else if (cnt_q == TMO_LAST) begin
                    rsp_dat_d = 32'd0;
                    rsp_err_d = 1'b1;
                    rsp_tmo_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            adr_q     <= 32'd0;
            dat_q     <= 32'd0;
            sel_q     <= 4'd0;
            cnt_q     <= 8'd0;
            rsp_dat_q <= 32'd0;
            rsp_err_q <= 1'b0;
            rsp_tmo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
            rsp_tmo_q <= rsp_tmo_d;
        end
    end

    // cyc/stb decode from state so an asynchronous reset drops them at once
    assign wbm_cyc_o   = (state_q == BUS);
    assign wbm_stb_o   = (state_q == BUS);
    assign cmd_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign busy_o      = (state_q != IDLE);
    assign wbm_we_o    = we_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = sel_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_tmo_o   = rsp_tmo_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: configurable Wishbone slave, transfer-level reference model, directed and random transfers.
module tb_wb_cmd_master;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err, rsp_tmo;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i, wbm_err_i;
    logic [31:0] wbm_dat_i;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .rsp_tmo_o   (rsp_tmo),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_err_i   (wbm_err_i),
        .wbm_dat_i   (wbm_dat_i),
        .busy_o      (busy)
    );

    // Slave: answers in STB cycle slv_delay (0 = combinational), or as a registered-ack slave.
    // slv_kind: 0 ACK, 1 ERR, 2 ACK+ERR.
    int          slv_delay = 0;
    int          slv_kind = 0;
    logic        slv_reg = 1'b0;
    logic [31:0] slv_rdata = 32'd0;
    int          stb_cnt = 0;
    logic        reg_ack_q = 1'b0;
    logic        hit;

    always @(posedge clk) begin
        stb_cnt   <= wbm_cyc_o ? stb_cnt + 1 : 0;
        reg_ack_q <= wbm_cyc_o & wbm_stb_o;
    end

    assign hit       = wbm_cyc_o && !slv_reg && (stb_cnt == slv_delay);
    assign wbm_ack_i = slv_reg ? reg_ack_q : (hit && slv_kind != 1);
    assign wbm_err_i = hit && slv_kind != 0;
    assign wbm_dat_i = slv_rdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; returns just after a negedge.
    task automatic run_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input int d, input int kind,
                            input logic [31:0] rdata, input int hold, input logic reg_mode,
                            input logic pend);
        int          eff, exp_len, ncyc;
        logic        timeout, exp_err;
        logic [31:0] exp_dat;
        eff     = reg_mode ? 1 : d;
        timeout = (eff >= TMO);
        exp_len = timeout ? TMO : eff + 1;
        exp_err = timeout || (!reg_mode && kind != 0);
        exp_dat = (exp_err || we) ? 32'd0 : rdata;

        slv_delay = d;
        slv_kind  = kind;
        slv_reg   = reg_mode;
        slv_rdata = rdata;
        rsp_ready = 1'b0;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        ncyc = 0;
        while (wbm_cyc_o === 1'b1 && ncyc < 20) begin
            ncyc++;
            check_eq("bus_adr", wbm_adr_o, adr);
            check_eq("bus_dat", wbm_dat_o, dat);
            check_eq("bus_we_sel", {27'd0, wbm_we_o, wbm_sel_o}, {27'd0, we, sel});
            check_eq("bus_stb_rdy", {30'd0, wbm_stb_o, cmd_ready}, 32'h2);
            @(negedge clk);
        end
        check_eq("stb_len", ncyc, exp_len);
        check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("rsp_dat", rsp_dat, exp_dat);
        check_eq("rsp_err_tmo", {30'd0, rsp_err, rsp_tmo}, {30'd0, exp_err, timeout});
        for (int h = 0; h < hold; h++) begin
            if (pend) begin
                cmd_valid = 1'b1;
                cmd_we    = 1'b0;
                cmd_adr   = 32'hDEAD_0000;
                cmd_sel   = 4'hF;
            end
            @(negedge clk);
            check_eq("hold_valid", {30'd0, rsp_valid, cmd_ready}, 32'h2);
            check_eq("hold_dat", rsp_dat, exp_dat);
            check_eq("hold_err_tmo_cyc", {29'd0, rsp_err, rsp_tmo, wbm_cyc_o},
                     {29'd0, exp_err, timeout, 1'b0});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("post_idle", {29'd0, rsp_valid, busy, cmd_ready}, 32'h1);
        check_eq("post_cyc", 32'(wbm_cyc_o), 32'd0);
        check_eq("post_dat_hold", rsp_dat, exp_dat);
        if (!pend) begin
            @(negedge clk);
            check_eq("still_idle", {29'd0, rsp_valid, busy, wbm_cyc_o}, 32'd0);
        end
    endtask

    initial begin
        logic        r_we, r_reg;
        int          r_d, r_kind;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = 32'd0;
        cmd_dat   = 32'd0;
        cmd_sel   = 4'd0;
        rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_ctrl", {28'd0, cmd_ready, busy, wbm_cyc_o, rsp_valid}, 32'h8);
        check_eq("rst_adr", wbm_adr_o, 32'd0);
        check_eq("rst_rsp_dat", rsp_dat, 32'd0);
        check_eq("rst_misc", {27'd0, wbm_we_o, wbm_sel_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_release", {30'd0, cmd_ready, busy}, 32'h2);

        // registered-ack write
        run_xfer(1'b1, 32'h3000_0004, 32'hA5A5_0001, 4'hF, 0, 0, 32'h5555_AAAA, 0, 1'b1, 1'b0);
        // combinational-ack read
        run_xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 0, 32'h1234_5678, 0, 1'b0, 1'b0);
        // ACK and ERR together
        run_xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, 1, 2, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
        // silent slave -> timeout, then a normal command
        run_xfer(1'b0, 32'h3000_000C, 32'h0, 4'h3, 10, 0, 32'h0BAD_0BAD, 0, 1'b0, 1'b0);
        // ACK exactly on the limit edge
        run_xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, TMO - 1, 0, 32'h7777_1111, 0, 1'b0, 1'b0);
        // response held 3 cycles with a command pending, which is taken only afterwards
        run_xfer(1'b0, 32'h3000_0014, 32'h0, 4'hF, 2, 0, 32'h89AB_CDEF, 3, 1'b0, 1'b1);
        run_xfer(1'b0, 32'hDEAD_0000, 32'h0, 4'hF, 0, 0, 32'h0000_0042, 0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_reg  = ($urandom_range(0, 3) == 0);
            r_d    = $urandom_range(0, 6);
            r_kind = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            run_xfer(r_we, $urandom, $urandom, 4'($urandom_range(0, 15)), r_d, r_kind,
                     $urandom, $urandom_range(0, 2), r_reg, 1'b0);
        end

        // reset in the second BUS cycle
        slv_reg   = 1'b0;
        slv_delay = 10;
        slv_kind  = 0;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h3000_0020;
        cmd_sel   = 4'hF;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("rst_pre_cyc", 32'(wbm_cyc_o), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_cyc", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
        check_eq("rst_mid_rsp", {30'd0, rsp_valid, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_release", {29'd0, cmd_ready, busy, wbm_cyc_o}, 32'h4);
        check_eq("rst_mid_adr", wbm_adr_o, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
